bus_master_ctrl: RTL and testbench

BUS_MASTER_CTRL -- requirements
Module: bus_master_ctrl

---
 rtl/master_bus_pkg.sv | 72 +++++++
 rtl/bus_master_ctrl_if.sv | 31 +++
 rtl/bus_timeout_cnt.sv | 22 ++
 rtl/bus_master_ctrl.sv | 92 +++++++++
 tb/tb_bus_master_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/master_bus_pkg.sv
// Shared types for the bus master controller: FSM states, datapath bank encodings,
// select width and the per-state control decode used to register the outputs.
package master_bus_pkg;

  localparam int SEL_W = 2;

  localparam logic RW_CAPTURE = 1'b0;
  localparam logic RW_HOLD    = 1'b1;
  localparam logic RWA_OFF    = 1'b0;
  localparam logic RWA_DRIVE  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CAPT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic             cmd_ready;
    logic [SEL_W-1:0] sr;
    logic [SEL_W-1:0] dr;
    logic [SEL_W-1:0] srA;
    logic             rw;
    logic             rwA;
    logic             bus_req;
    logic             bus_we;
    logic             done;
    logic             busy;
  } ctl_t;

  // Control outputs seen while sitting in state s; selects stay 0 unless in use.
  function automatic ctl_t ctl_decode(state_t s, logic wr, logic [SEL_W-1:0] dreg,
                                      logic [SEL_W-1:0] areg);
    ctl_t c;
    c.cmd_ready = 1'b0;
    c.sr        = '0;
    c.dr        = '0;
    c.srA       = '0;
    c.rw        = RW_HOLD;
    c.rwA       = RWA_OFF;
    c.bus_req   = 1'b0;
    c.bus_we    = 1'b0;
    c.done      = 1'b0;
    c.busy      = 1'b1;
    case (s)
      S_IDLE: begin
        c.cmd_ready = 1'b1;
        c.busy      = 1'b0;
      end
      S_ADDR, S_WAIT: begin
        c.srA     = areg;
        c.rwA     = RWA_DRIVE;
        c.bus_req = 1'b1;
        c.bus_we  = wr;
        if (s == S_WAIT && wr) c.sr = dreg;
      end
      S_CAPT: begin
        c.srA     = areg;
        c.rwA     = RWA_DRIVE;
        c.bus_req = 1'b1;
        c.dr      = dreg;
        c.rw      = RW_CAPTURE;
      end
      S_DONE: c.done = 1'b1;
      default: c.busy = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Command, slave and datapath-control bundle of the bus master controller.
interface bus_master_ctrl_if;
  import master_bus_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [SEL_W-1:0] cmd_dreg;
  logic [SEL_W-1:0] cmd_areg;
  logic             slv_ack;
  logic [SEL_W-1:0] sr;
  logic [SEL_W-1:0] dr;
  logic [SEL_W-1:0] srA;
  logic             rw;
  logic             rwA;
  logic             bus_req;
  logic             bus_we;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_write, cmd_dreg, cmd_areg, slv_ack,
    output cmd_ready, sr, dr, srA, rw, rwA, bus_req, bus_we, done, err, busy
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_dreg, cmd_areg, slv_ack,
    input  cmd_ready, sr, dr, srA, rw, rwA, bus_req, bus_we, done, err, busy
  );
endinterface

// File: rtl/bus_timeout_cnt.sv
// WAIT-cycle counter; o_expired is high during the TIMEOUT_CYCLES-th enabled cycle.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;

  assign o_expired = i_enable && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_cnt <= '0;
    else if (i_clear)               r_cnt <= '0;
    else if (i_enable && !o_expired) r_cnt <= r_cnt + 8'd1;
  end
endmodule

// File: rtl/bus_master_ctrl.sv
// Bus master controller: one command per IDLE visit, ADDR->WAIT->(CAPT)->DONE.
// Optional WAIT timeout with error flag when BUS_MASTER_CTRL_TIMEOUT_EN is defined.
module bus_master_ctrl
  import master_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  bus_master_ctrl_if.master  bus
);
  state_t           r_state, w_nxt;
  logic             r_write;
  logic [SEL_W-1:0] r_dreg, r_areg;
  ctl_t             r_ctl;
  logic             w_hs, w_in_wait, w_expired;

  assign w_hs      = bus.cmd_valid & r_ctl.cmd_ready;
  assign w_in_wait = (r_state == S_WAIT);

`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
  logic r_err;

  bus_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_in_wait),
    .i_enable  (w_in_wait),
    .o_expired (w_expired)
  );

  // Error holds across IDLE so software can read it; the next handshake clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_err <= 1'b0;
    else if (w_hs)                                    r_err <= 1'b0;
    else if (w_in_wait && !bus.slv_ack && w_expired) r_err <= 1'b1;
  end

  assign bus.err = r_err;
`else
  assign w_expired = 1'b0;
  assign bus.err   = 1'b0;
`endif

  // Ack outranks an expiry landing on the same cycle.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_hs) w_nxt = S_ADDR;
      S_ADDR: w_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.slv_ack)    w_nxt = r_write ? S_DONE : S_CAPT;
        else if (w_expired) w_nxt = S_DONE;
      end
      S_CAPT: w_nxt = S_DONE;
      S_DONE: w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_dreg  <= '0;
      r_areg  <= '0;
      r_ctl   <= ctl_decode(S_IDLE, 1'b0, '0, '0);
    end else begin
      r_state <= w_nxt;
      if (w_hs) begin
        r_write <= bus.cmd_write;
        r_dreg  <= bus.cmd_dreg;
        r_areg  <= bus.cmd_areg;
      end
      r_ctl <= ctl_decode(w_nxt,
                          w_hs ? bus.cmd_write : r_write,
                          w_hs ? bus.cmd_dreg  : r_dreg,
                          w_hs ? bus.cmd_areg  : r_areg);
    end
  end

  assign bus.cmd_ready = r_ctl.cmd_ready;
  assign bus.sr        = r_ctl.sr;
  assign bus.dr        = r_ctl.dr;
  assign bus.srA       = r_ctl.srA;
  assign bus.rw        = r_ctl.rw;
  assign bus.rwA       = r_ctl.rwA;
  assign bus.bus_req   = r_ctl.bus_req;
  assign bus.bus_we    = r_ctl.bus_we;
  assign bus.done      = r_ctl.done;
  assign bus.busy      = r_ctl.busy;
endmodule

// File: tb/tb_bus_master_ctrl.sv
// Scoreboard bench for bus_master_ctrl: driver pushes the expected completion per
// command, a negedge monitor checks per-cycle outputs and pops on each done pulse.
module tb_bus_master_ctrl;
  import master_bus_pkg::*;

  localparam int T = 4;

  typedef struct {
    logic       wr;
    logic [1:0] dreg;
    logic [1:0] areg;
    int         lat;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bus_master_ctrl_if bif ();

  bus_master_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: k = WAIT cycle (1-based) carrying the ack, 0 = no ack at all.
  function automatic exp_t model(logic wr, logic [1:0] d, logic [1:0] a, int k);
    exp_t e;
    bit   tmo;
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
    tmo = (k == 0) || (k > T);
`else
    tmo = 1'b0;
`endif
    e.wr   = wr;
    e.dreg = d;
    e.areg = a;
    e.err  = tmo;
    e.lat  = tmo ? T + 2 : (wr ? k + 2 : k + 3);
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, bif.cmd_ready, 1);
    chk({tag, "_sr"},        bif.sr, 0);
    chk({tag, "_dr"},        bif.dr, 0);
    chk({tag, "_srA"},       bif.srA, 0);
    chk({tag, "_rw"},        bif.rw, 1);
    chk({tag, "_rwA"},       bif.rwA, 0);
    chk({tag, "_bus_req"},   bif.bus_req, 0);
    chk({tag, "_bus_we"},    bif.bus_we, 0);
    chk({tag, "_done"},      bif.done, 0);
    chk({tag, "_err"},       bif.err, 0);
    chk({tag, "_busy"},      bif.busy, 0);
  endtask

  // Presents one command (cmd_valid left high afterwards) and plays the ack at WAIT k.
  task automatic run_cmd(input logic wr, input logic [1:0] d, input logic [1:0] a,
                         input int k, input bit noise);
    exp_t e;
    bit   got;
    bif.cmd_valid = 1'b1;
    bif.cmd_write = wr;
    bif.cmd_dreg  = d;
    bif.cmd_areg  = a;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (bif.cmd_ready === 1'b1) got = 1'b1;
    end
    if (!got) begin
      chk("handshake_timeout", 0, 1);
      return;
    end
    e = model(wr, d, a, k);
    q.push_back(e);
    @(posedge clk); #1;
    bif.slv_ack   = noise;
    bif.cmd_write = 1'($urandom);
    bif.cmd_dreg  = 2'($urandom);
    bif.cmd_areg  = 2'($urandom);
    for (int c = 2; c <= e.lat; c++) begin
      @(posedge clk); #1;
      bif.slv_ack = (c == k + 1);
    end
    @(posedge clk); #1;
    bif.slv_ack = 1'($urandom);
  endtask

  // Monitor state
  bit         m_active = 1'b0;
  int         m_cyc;
  logic       m_wr;
  logic [1:0] m_d, m_a;
  int         m_capt_n;
  logic [1:0] m_capt_dr;
  logic       m_last_err = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      m_active   = 1'b0;
      m_last_err = 1'b0;
    end else if (m_active) begin
      m_cyc++;
      chk("busy_active", bif.busy, 1);
      chk("ready_active", bif.cmd_ready, 0);
      chk("rwA_eq_req", bif.rwA, bif.bus_req);
      chk("srA_sel", bif.srA, bif.rwA ? m_a : 2'd0);
      chk("sr_sel", bif.sr, (m_wr && bif.bus_req && m_cyc >= 2) ? m_d : 2'd0);
      chk("dr_sel", bif.dr, bif.rw ? 2'd0 : m_d);
      if (bif.bus_req) chk("bus_we", bif.bus_we, m_wr);
      if (m_cyc == 1) chk("addr_req", bif.bus_req, 1);
      if (bif.rw === RW_CAPTURE) begin
        m_capt_n++;
        m_capt_dr = bif.dr;
      end
      if (bif.done === 1'b1) begin
        chk("done_req_drop", bif.bus_req, 0);
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sb_dir", m_wr, e.wr);
          chk("latency", m_cyc, e.lat);
          chk("err", bif.err, e.err);
          chk("capt_cycles", m_capt_n, (!e.wr && !e.err) ? 1 : 0);
          if (!e.wr && !e.err) chk("capt_dr", m_capt_dr, e.dreg);
          m_last_err = e.err;
        end
        m_active = 1'b0;
      end else begin
        chk("err_clear", bif.err, 0);
        if (m_cyc > 64) begin
          chk("done_timeout", 0, 1);
          m_active = 1'b0;
        end
      end
    end else begin
      chk("idle_ready", bif.cmd_ready, 1);
      chk("idle_busy", bif.busy, 0);
      chk("idle_done", bif.done, 0);
      chk("idle_req", bif.bus_req, 0);
      chk("idle_err_hold", bif.err, m_last_err);
      if (bif.cmd_valid === 1'b1 && bif.cmd_ready === 1'b1) begin
        m_active  = 1'b1;
        m_cyc     = 0;
        m_capt_n  = 0;
        m_capt_dr = 2'd0;
        m_wr      = bif.cmd_write;
        m_d       = bif.cmd_dreg;
        m_a       = bif.cmd_areg;
      end
    end
  end

  initial begin
    rst           = 1'b1;
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_dreg  = 2'd0;
    bif.cmd_areg  = 2'd0;
    bif.slv_ack   = 1'b0;
    #2;
    check_reset_outputs("rst0");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Write, ack on first WAIT cycle; then slow read (ack on 6th WAIT -> done at +9).
    run_cmd(1'b1, 2'd2, 2'd1, 1, 1'b0);
    run_cmd(1'b0, 2'd3, 2'd2, 6, 1'b1);
    // Ack on the same cycle the timeout would expire: normal completion.
    run_cmd(1'b1, 2'd1, 2'd3, T, 1'b0);
    run_cmd(1'b0, 2'd2, 2'd0, T, 1'b0);
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
    run_cmd(1'b1, 2'd2, 2'd1, 0, 1'b0);
    run_cmd(1'b0, 2'd1, 2'd2, 0, 1'b0);
    run_cmd(1'b1, 2'd3, 2'd3, 1, 1'b0);
`endif

    // Reset in the middle of WAIT; a late ack after release must be ignored.
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_dreg  = 2'd3;
    bif.cmd_areg  = 2'd2;
    bif.slv_ack   = 1'b0;
    @(negedge clk);
    chk("rst_test_ready", bif.cmd_ready, 1);
    @(posedge clk); @(posedge clk); @(posedge clk); #1;
    chk("rst_test_in_wait", bif.bus_req, 1);
    rst = 1'b1;
    bif.cmd_valid = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    rst = 1'b0;
    bif.slv_ack = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    bif.slv_ack = 1'b0;
    chk("late_ack_ignored", bif.bus_req, 0);
    run_cmd(1'b0, 2'd1, 2'd3, 2, 1'b0);

    // Randomized back-to-back traffic with occasional idle gaps.
    for (int n = 0; n < 40; n++) begin
      int k;
      if ($urandom_range(0, 3) == 0) begin
        bif.cmd_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
`ifdef BUS_MASTER_CTRL_TIMEOUT_EN
      k = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, T + 2));
`else
      k = int'($urandom_range(1, 8));
`endif
      run_cmd(1'($urandom), 2'($urandom), 2'($urandom), k, 1'($urandom));
    end

    bif.cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
